// File: rtl/ext_mem_boot_ctrl.sv
// ext_mem_boot_ctrl: word memory that first streams a padded boot image
// out of its load token port, then serves pipelined loads and stores.
// Ports: clock, reset (async, active-low); I_Boot starts the boot stream;
//   I_Pre_We/Addr/Data preload memory in IDLE; I_Ld_Req/Addr issue loads,
//   O_Ld_FTk returns them, I_Ld_BTk.n stalls the load pipe; I_St_Req/Addr
//   with I_St_FTk write memory, O_St_BTk.n = not ready; O_Busy is high
//   while the boot stream runs; O_AddrErr is a sticky out-of-range flag.
package ext_mem_boot_pkg;
    localparam int FTK_DW = 32;
    localparam int FTK_IW = 32;

    typedef struct packed {
        logic              v;
        logic              a;
        logic              r;
        logic              c;
        logic [FTK_IW-1:0] i;
        logic [FTK_DW-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
    } BTk_t;
endpackage

module ext_mem_boot_ctrl
    import ext_mem_boot_pkg::*;
#(
    // Token fields are sized by the package; keep these equal to them.
    parameter int WIDTH_DATA   = FTK_DW,
    parameter int WIDTH_EXADDR = FTK_IW,
    parameter int DEPTH        = 1024,
    parameter int BOOT_PAD     = 3,
    parameter int BOOT_LEN     = 5,
    parameter int RD_LAT       = 1,
    parameter int EXTEND_IDX   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Pre_We,
    input  logic [WIDTH_EXADDR-1:0] I_Pre_Addr,
    input  logic [WIDTH_DATA-1:0]   I_Pre_Data,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output FTk_t                    O_Ld_FTk,
    input  BTk_t                    I_Ld_BTk,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  FTk_t                    I_St_FTk,
    output BTk_t                    O_St_BTk,
    output logic                    O_Busy,
    output logic                    O_AddrErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAD,
        S_BOOT,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            st_n_q, st_n_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    // Last stage doubles as the output register for the boot stream.
    FTk_t            pipe_q [RD_LAT];
    FTk_t            pipe_d [RD_LAT];
    logic [WIDTH_DATA-1:0] mem_q [DEPTH];

    logic                  mem_we;
    logic [AW-1:0]         mem_wa;
    logic [WIDTH_DATA-1:0] mem_wd;
    logic                  ld_ok, st_ok, pre_ok;
    logic                  ld_acc, st_fire, pre_fire;
    FTk_t                  ld_tok, boot_tok;
    logic                  unused_st_tok;

    function automatic logic in_range(input logic [WIDTH_EXADDR-1:0] a);
        return (a >> AW) == '0;
    endfunction

    assign unused_st_tok = ^{I_St_FTk.a, I_St_FTk.r,
                             I_St_FTk.c, I_St_FTk.i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_Boot) begin
                    cnt_d   = '0;
                    state_d = (BOOT_PAD > 0) ? S_PAD :
                              (BOOT_LEN > 0) ? S_BOOT : S_RUN;
                end
            end
            S_PAD: begin
                if (cnt_q == CW'(BOOT_PAD - 1)) begin
                    cnt_d   = '0;
                    state_d = (BOOT_LEN > 0) ? S_BOOT : S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BOOT: begin
                if (cnt_q == CW'(BOOT_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_ok    = in_range(I_Ld_Addr);
        st_ok    = in_range(I_St_Addr);
        pre_ok   = in_range(I_Pre_Addr);
        ld_acc   = (state_q == S_RUN) && I_Ld_Req && !I_Ld_BTk.n;
        st_fire  = I_St_Req && I_St_FTk.v && !st_n_q;
        pre_fire = (state_q == S_IDLE) && I_Pre_We;

        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = '0;
        if (st_fire && st_ok) begin
            mem_we = 1'b1;
            mem_wa = I_St_Addr[AW-1:0];
            mem_wd = I_St_FTk.d;
        end else if (pre_fire && pre_ok) begin
            mem_we = 1'b1;
            mem_wa = I_Pre_Addr[AW-1:0];
            mem_wd = I_Pre_Data;
        end

        // Write-first: a same-cycle store to the load address wins.
        ld_tok   = '0;
        ld_tok.v = 1'b1;
        ld_tok.i = (EXTEND_IDX != 0) ? I_Ld_Addr : '0;
        if (ld_ok) begin
            if (st_fire && st_ok && (I_St_Addr == I_Ld_Addr)) begin
                ld_tok.d = I_St_FTk.d;
            end else begin
                ld_tok.d = mem_q[I_Ld_Addr[AW-1:0]];
            end
        end

        err_d = err_q
              | (ld_acc && !ld_ok)
              | (st_fire && !st_ok)
              | (pre_fire && !pre_ok);
        st_n_d = (state_d != S_RUN);
        busy_d = (state_d == S_PAD) || (state_d == S_BOOT);
    end

    always_comb begin
        boot_tok   = '0;
        boot_tok.v = 1'b1;
        if (state_d == S_PAD) begin
            boot_tok.a = (cnt_d == '0);
        end else begin
            boot_tok.d = mem_q[AW'(cnt_d)];
            boot_tok.i = (EXTEND_IDX != 0) ? FTK_IW'(cnt_d) : '0;
        end
    end

    always_comb begin
        for (int k = 0; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k];
        end
        unique case (state_d)
            S_PAD, S_BOOT: begin
                for (int k = 0; k < RD_LAT; k++) begin
                    pipe_d[k] = '0;
                end
                pipe_d[RD_LAT-1] = boot_tok;
            end
            S_RUN: begin
                // The BOOT->RUN edge always shifts so the last boot
                // word cannot linger under a stall.
                if ((state_q != S_RUN) || !I_Ld_BTk.n) begin
                    pipe_d[0] = ld_acc ? ld_tok : '0;
                    for (int k = 1; k < RD_LAT; k++) begin
                        pipe_d[k] = pipe_q[k-1];
                    end
                end
            end
            default: begin
                for (int k = 0; k < RD_LAT; k++) begin
                    pipe_d[k] = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            st_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_n_q  <= st_n_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign O_Ld_FTk   = pipe_q[RD_LAT-1];
    assign O_St_BTk.n = st_n_q;
    assign O_Busy     = busy_q;
    assign O_AddrErr  = err_q;
endmodule

// File: tb/tb_ext_mem_boot_ctrl.sv
// tb_ext_mem_boot_ctrl: directed + random bench for ext_mem_boot_ctrl.
// Reference model tracks memory, mode and per-load timestamps.
module tb_ext_mem_boot_ctrl;
    import ext_mem_boot_pkg::*;

    localparam int DEPTH    = 16;
    localparam int BOOT_PAD = 3;
    localparam int BOOT_LEN = 5;
    localparam int RD_LAT   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Boot, I_Pre_We, I_Ld_Req, I_St_Req;
    logic [31:0] I_Pre_Addr, I_Pre_Data, I_Ld_Addr, I_St_Addr;
    FTk_t        O_Ld_FTk, I_St_FTk;
    BTk_t        I_Ld_BTk, O_St_BTk;
    logic        O_Busy, O_AddrErr;

    always #5 clock = ~clock;

    ext_mem_boot_ctrl #(
        .WIDTH_DATA(32), .WIDTH_EXADDR(32), .DEPTH(DEPTH),
        .BOOT_PAD(BOOT_PAD), .BOOT_LEN(BOOT_LEN),
        .RD_LAT(RD_LAT), .EXTEND_IDX(1)
    ) dut (
        .clock(clock), .reset(reset), .I_Boot(I_Boot),
        .I_Pre_We(I_Pre_We), .I_Pre_Addr(I_Pre_Addr),
        .I_Pre_Data(I_Pre_Data), .I_Ld_Req(I_Ld_Req),
        .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk),
        .I_Ld_BTk(I_Ld_BTk), .I_St_Req(I_St_Req),
        .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk),
        .O_St_BTk(O_St_BTk), .O_Busy(O_Busy), .O_AddrErr(O_AddrErr)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_mode;   // 0 idle, 1 boot stream, 2 run
    int          m_k;      // boot stream word index
    int          adv;      // count of advancing RUN edges
    bit          m_err;
    logic [31:0] exp_d [int];
    logic [31:0] exp_i [int];
    logic [31:0] got [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        ev, ea;
        logic [31:0] ed, ei;
        bit          full;
        int          t;
        ev = 0; ea = 0; ed = 0; ei = 0; full = 1;
        if (m_mode == 1) begin
            ev = 1;
            if (m_k < BOOT_PAD) ea = (m_k == 0);
            else begin
                ed = m_mem[4'(m_k - BOOT_PAD)];
                ei = 32'(m_k - BOOT_PAD);
            end
        end else if (m_mode == 2) begin
            t = adv - RD_LAT + 1;
            if (exp_d.exists(t)) begin
                ev = 1; ed = exp_d[t]; ei = exp_i[t];
            end else full = 0;
        end
        check({tag, ".v"}, 32'(O_Ld_FTk.v), 32'(ev));
        check({tag, ".a"}, 32'(O_Ld_FTk.a), 32'(ea));
        check({tag, ".r"}, 32'(O_Ld_FTk.r), 32'd0);
        check({tag, ".c"}, 32'(O_Ld_FTk.c), 32'd0);
        if (full) begin
            check({tag, ".d"}, O_Ld_FTk.d, ed);
            check({tag, ".i"}, O_Ld_FTk.i, ei);
        end
        check({tag, ".st_n"}, 32'(O_St_BTk.n), 32'(m_mode != 2));
        check({tag, ".busy"}, 32'(O_Busy), 32'(m_mode == 1));
        check({tag, ".err"}, 32'(O_AddrErr), 32'(m_err));
    endtask

    // Applies the upcoming rising edge to the model, then advances time
    // to the following falling edge where outputs are sampled.
    task automatic cycle();
        if (m_mode == 2 && !I_Ld_BTk.n && O_Ld_FTk.v)
            got.push_back(O_Ld_FTk.d);
        if (m_mode == 0) begin
            if (I_Pre_We) begin
                if (I_Pre_Addr < 32'(DEPTH)) m_mem[I_Pre_Addr[3:0]] = I_Pre_Data;
                else m_err = 1;
            end
            if (I_Boot) begin m_mode = 1; m_k = 0; end
        end else if (m_mode == 1) begin
            m_k++;
            if (m_k == BOOT_PAD + BOOT_LEN) begin m_mode = 2; adv = 0; end
        end else begin
            if (I_St_Req && I_St_FTk.v) begin
                if (I_St_Addr < 32'(DEPTH)) m_mem[I_St_Addr[3:0]] = I_St_FTk.d;
                else m_err = 1;
            end
            if (!I_Ld_BTk.n) begin
                adv++;
                if (I_Ld_Req) begin
                    exp_i[adv] = I_Ld_Addr;
                    if (I_Ld_Addr < 32'(DEPTH)) exp_d[adv] = m_mem[I_Ld_Addr[3:0]];
                    else begin exp_d[adv] = 0; m_err = 1; end
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        I_Boot = 0; I_Pre_We = 0; I_Pre_Addr = 0; I_Pre_Data = 0;
        I_Ld_Req = 0; I_Ld_Addr = 0; I_Ld_BTk = '0;
        I_St_Req = 0; I_St_Addr = 0; I_St_FTk = '0;
    endtask

    task automatic apply_reset(input string tag);
        clear_inputs();
        reset = 0;
        m_mode = 0; m_k = 0; adv = 0; m_err = 0;
        exp_d.delete(); exp_i.delete();
        #1 check_all(tag);
        @(posedge clock);
        @(negedge clock);
        check_all(tag);
        reset = 1;
    endtask

    task automatic load(input logic [31:0] a, input string tag);
        I_Ld_Req = 1; I_Ld_Addr = a;
        cycle();
        I_Ld_Req = 0;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int c = 0; c < n; c++) begin cycle(); check_all(tag); end
    endtask

    task automatic boot_stream(input string tag);
        I_Boot = 1;
        cycle();
        I_Boot = 0;
        check_all({tag, ".pad0"});
        for (int c = 1; c <= BOOT_PAD + BOOT_LEN; c++) begin
            cycle();
            check_all(tag);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        #2 apply_reset("reset");

        for (int a = 0; a < DEPTH; a++) begin
            I_Pre_We = 1; I_Pre_Addr = a;
            I_Pre_Data = (a < 5) ? 32'((a + 1) * 11) :
                         (a == 7) ? 32'hABCD : $urandom;
            cycle();
            check_all("preload");
        end
        I_Pre_We = 0;

        // Boot stream; BTk stalls, a store and preloads are all ignored.
        I_Boot = 1;
        cycle();
        I_Boot = 0;
        check_all("boot.pad0");
        for (int c = 1; c <= BOOT_PAD + BOOT_LEN; c++) begin
            I_Ld_BTk.n = 1'($urandom_range(0, 1));
            if (c == 5) begin
                I_St_Req = 1; I_St_Addr = 2;
                I_St_FTk.v = 1; I_St_FTk.d = 32'hDEAD;
                I_Pre_We = 1; I_Pre_Addr = 3; I_Pre_Data = 32'hBAD;
            end
            if (c == 6) begin
                I_Pre_We = 1; I_Pre_Addr = 20; I_Pre_Data = 1;
            end
            cycle();
            clear_inputs();
            check_all("boot");
        end

        load(7, "lat");
        idle(4, "lat");

        got.delete();
        load(1, "b2b");
        load(2, "b2b");
        I_Ld_BTk.n = 1; I_Ld_Req = 1; I_Ld_Addr = 3;
        cycle(); check_all("stall");
        cycle(); check_all("stall");
        I_Ld_BTk.n = 0;
        load(3, "b2b");
        idle(5, "b2b");
        check("b2b.count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("b2b.r0", got[0], 32'd22);
            check("b2b.r1", got[1], 32'd33);
            check("b2b.r2", got[2], 32'd44);
        end

        got.delete();
        I_St_Req = 1; I_St_Addr = 9; I_St_FTk.v = 1; I_St_FTk.d = 32'h55;
        load(9, "wf");
        clear_inputs();
        idle(4, "wf");
        check("wf.count", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("wf.data", got[0], 32'h55);

        load(DEPTH + 1, "oor");
        check("oor.err", 32'(O_AddrErr), 32'd1);
        I_St_Req = 1; I_St_Addr = 20; I_St_FTk.v = 1; I_St_FTk.d = 7;
        cycle(); clear_inputs(); check_all("oor_st");
        load(32'h8000_0003, "oor_hi");
        idle(5, "oor");
        check("oor.sticky", 32'(O_AddrErr), 32'd1);

        for (int c = 0; c < 300; c++) begin
            I_Ld_Req = 1'($urandom_range(0, 1));
            I_Ld_Addr = $urandom_range(0, 19);
            I_Ld_BTk.n = ($urandom_range(0, 3) == 0);
            I_St_Req = 1'($urandom_range(0, 1));
            I_St_Addr = $urandom_range(0, 17);
            I_St_FTk.v = 1'($urandom_range(0, 1));
            I_St_FTk.d = $urandom;
            cycle();
            check_all("rand");
        end
        clear_inputs();
        idle(5, "drain");

        load(5, "rst_run");
        apply_reset("rst_run");
        idle(2, "rst_idle");
        I_Boot = 1;
        cycle();
        I_Boot = 0;
        check_all("reboot.pad0");
        for (int c = 1; c <= BOOT_PAD + 2; c++) begin
            cycle();
            check_all("reboot");
        end
        apply_reset("rst_boot");
        idle(3, "rst_wait");
        boot_stream("reboot2");
        load(9, "post");
        idle(4, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
